// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: default geometry of
// the unified instruction/data memory and the controller state encoding.
package mem_access_ctrl_pkg;

  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MEM_WORDS = 50;
  localparam int unsigned ERRCNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_access_ctrl_addr_check.sv
// mem_addr_check: combinational byte-address decoder.
//   byte_addr_i : 32-bit byte address from the request
//   word_idx_o  : word index, byte_addr_i[ADDR_W+1:2]
//   err_o       : misaligned, upper bits set, or index beyond MEM_WORDS
module mem_addr_check #(
  parameter int unsigned ADDR_W    = mem_access_ctrl_pkg::ADDR_W,
  parameter int unsigned MEM_WORDS = mem_access_ctrl_pkg::MEM_WORDS
) (
  input  logic [31:0]       byte_addr_i,
  output logic [ADDR_W-1:0] word_idx_o,
  output logic              err_o
);

  always_comb begin
    word_idx_o = byte_addr_i[ADDR_W+1:2];
    err_o      = (byte_addr_i[1:0] != 2'b00)
              || (byte_addr_i[31:ADDR_W+2] != '0)
              || (32'(word_idx_o) >= MEM_WORDS);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator side of the unified instruction/data memory.
// Accepts one word request at a time, performs a single-cycle memory access,
// and returns the result on a valid/ready response channel. Bad addresses are
// rejected without a memory strobe and counted in a saturating counter.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake; req_write, req_addr, req_wdata
//   resp_valid/resp_ready : response handshake; resp_rdata, resp_err
//   mem_addr, mem_wdata   : word address and store data to memory
//   mem_write, mem_read   : access strobes (ACCESS cycle only)
//   mem_rdata             : combinational read data from memory
//   err_count             : saturating count of rejected requests
module mem_access_ctrl #(
  parameter int unsigned ADDR_W    = mem_access_ctrl_pkg::ADDR_W,
  parameter int unsigned DATA_W    = mem_access_ctrl_pkg::DATA_W,
  parameter int unsigned MEM_WORDS = mem_access_ctrl_pkg::MEM_WORDS,
  parameter int unsigned ERRCNT_W  = mem_access_ctrl_pkg::ERRCNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_write,
  output logic                mem_read,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [ERRCNT_W-1:0] err_count
);

  import mem_access_ctrl_pkg::*;

  state_e              state_q;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic                resp_err_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                mem_write_q;
  logic                mem_read_q;
  logic                wr_q;
  logic [ERRCNT_W-1:0] err_count_q;

  logic [ADDR_W-1:0]   chk_idx;
  logic                chk_err;

  mem_addr_check #(
    .ADDR_W    (ADDR_W),
    .MEM_WORDS (MEM_WORDS)
  ) u_addr_check (
    .byte_addr_i (req_addr),
    .word_idx_o  (chk_idx),
    .err_o       (chk_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      wr_q         <= 1'b0;
      err_count_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            wr_q        <= req_write;
            if (chk_err) begin
              // Rejected: memory port untouched, response issued directly.
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
              if (err_count_q != '1) err_count_q <= err_count_q + 1'b1;
            end else begin
              // Strobes are registered here so they are high exactly in ACCESS.
              state_q     <= ACCESS;
              mem_addr_q  <= chk_idx;
              mem_wdata_q <= req_wdata;
              mem_write_q <= req_write;
              mem_read_q  <= ~req_write;
            end
          end
        end
        ACCESS: begin
          state_q      <= RESP;
          mem_write_q  <= 1'b0;
          mem_read_q   <= 1'b0;
          resp_rdata_q <= wr_q ? '0 : mem_rdata;
          resp_err_q   <= 1'b0;
          resp_valid_q <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  // Gated by reset so a store caught mid-flight by reset is never committed.
  assign mem_write  = mem_write_q & ~reset;
  assign mem_read   = mem_read_q & ~reset;
  assign err_count  = err_count_q;

endmodule
